// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential radix-2 multiply/divide unit, UMULL/SMULL/UDIV/SDIV.
// Ports: clk, reset, start, op, a, b -> busy, done, result_lo, result_hi, div_by_zero.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_div;
  logic            neg_lo;
  logic            neg_hi;
  logic [WIDTH-1:0] opb;
  logic [W2-1:0]   acc;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             accept;
  logic             dbz_now;

  assign a_neg   = op[0] & a[WIDTH-1];
  assign b_neg   = op[0] & b[WIDTH-1];
  assign a_mag   = a_neg ? (~a + 1'b1) : a;
  assign b_mag   = b_neg ? (~b + 1'b1) : b;
  assign accept  = start && (state == IDLE || state == DONE);
  assign dbz_now = op[1] && (b == '0);

  // Multiply: acc = {partial, multiplier}, add then shift right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[W2-1:WIDTH]}
                 + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};

  // Divide: acc = {remainder, quotient}, shift left then trial-subtract.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] div_diff;
  assign rem_sh   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opb};

  logic [W2-1:0] acc_step;
  always_comb begin
    acc_step = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_diff[WIDTH])
        acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fix: full-width negate for products, per-half for divides.
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  assign prod_fix = neg_lo ? (~acc + 1'b1) : acc;
  assign quo_fix  = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fix  = neg_hi ? (~acc[W2-1:WIDTH] + 1'b1) : acc[W2-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      opb         <= '0;
      acc         <= '0;
    end else if (accept) begin
      if (dbz_now) begin
        state       <= DONE;
        busy        <= 1'b0;
        done        <= 1'b1;
        div_by_zero <= 1'b1;
        result_lo   <= '1;
        result_hi   <= a;
      end else begin
        state       <= RUN;
        busy        <= 1'b1;
        done        <= 1'b0;
        div_by_zero <= 1'b0;
        cnt         <= '0;
        is_div      <= op[1];
        neg_lo      <= a_neg ^ b_neg;
        neg_hi      <= op[1] ? a_neg : (a_neg ^ b_neg);
        opb         <= op[1] ? b_mag : a_mag;
        acc         <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
      end
    end else begin
      unique case (state)
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (is_div) begin
            result_lo <= quo_fix;
            result_hi <= rem_fix;
          end else begin
            result_lo <= prod_fix[WIDTH-1:0];
            result_hi <= prod_fix[W2-1:WIDTH];
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq at WIDTH=32.
// Expected results are queued at issue and compared on each done pulse.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        div_by_zero;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .result_lo(result_lo),
    .result_hi(result_hi),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   busy_cnt = 0;
  int   e0;
  int   busy_base;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'(0));
      end else begin
        e = sb.pop_front();
        check("result_lo", 64'(result_lo), 64'(e.lo));
        check("result_hi", 64'(result_hi), 64'(e.hi));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
      end
    end
  end

  function automatic exp_t model(input logic [1:0] o,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t   e;
    longint sx;
    longint sy;
    logic [63:0] p;
    e = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin
        p = 64'(x) * 64'(y);
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      2'd1: begin
        p = 64'(sx * sy);
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      default: begin
        if (y == 0) begin
          e.lo = '1;
          e.hi = x;
          e.dbz = 1'b1;
        end else if (o == 2'd2) begin
          e.lo = x / y;
          e.hi = x % y;
        end else begin
          e.lo = 32'(sx / sy);
          e.hi = 32'(sx % sy);
        end
      end
    endcase
    return e;
  endfunction

  // Drives start for one edge; caller positions us before a rising edge.
  task automatic issue(input logic [1:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input bit push,
                       input exp_t e);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
    busy_base = busy_cnt;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - e0 + 1;
        return;
      end
    end
  endtask

  function automatic exp_t mk(input logic [31:0] hi,
                              input logic [31:0] lo,
                              input logic dbz);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.dbz = dbz;
    return e;
  endfunction

  initial begin
    int lat;
    int nd;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_lo", 64'(result_lo), 64'(0));
    check("rst_hi", 64'(result_hi), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    @(negedge clk);
    issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,
          mk(32'hFFFFFFFE, 32'h00000001, 1'b0));
    wait_done(lat);
    check("umull_lat", 64'(lat), 64'(34));
    check("umull_busy", 64'(busy_cnt - busy_base), 64'(33));

    @(negedge clk);
    issue(2'd1, 32'hFFFFFFFE, 32'd3, 1,
          mk(32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0));
    wait_done(lat);
    check("smull_lat", 64'(lat), 64'(34));

    @(negedge clk);
    issue(2'd2, 32'd100, 32'd7, 1, mk(32'd2, 32'd14, 1'b0));
    wait_done(lat);
    check("udiv_lat", 64'(lat), 64'(34));
    issue(2'd3, 32'hFFFFFFF9, 32'd2, 1,
          mk(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0));
    wait_done(lat);
    check("b2b_sdiv_lat", 64'(lat), 64'(34));

    @(negedge clk);
    issue(2'd2, 32'h1234, 32'd0, 1, mk(32'h1234, 32'hFFFFFFFF, 1'b1));
    wait_done(lat);
    check("dbz_lat", 64'(lat), 64'(1));

    @(negedge clk);
    issue(2'd3, 32'h80000000, 32'hFFFFFFFF, 1,
          mk(32'h0, 32'h80000000, 1'b0));
    wait_done(lat);
    check("sdiv_ovf_lat", 64'(lat), 64'(34));

    @(negedge clk);
    issue(2'd0, 32'd1234, 32'd5678, 1, mk(32'h0, 32'd7006652, 1'b0));
    repeat (5) @(negedge clk);
    check("run_busy", 64'(busy), 64'(1));
    check("run_hold_lo", 64'(result_lo), 64'(32'h80000000));
    start = 1'b1;
    op = 2'd1;
    a = 32'hDEADBEEF;
    b = 32'h00000099;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("midrun_lat", 64'(lat), 64'(34));

    @(negedge clk);
    issue(2'd0, 32'd7, 32'd9, 0, '0);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_lo", 64'(result_lo), 64'(0));
    check("abort_hi", 64'(result_hi), 64'(0));
    check("abort_dbz", 64'(div_by_zero), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", 64'(nd), 64'(0));

    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i == 3) rb = 32'd0;
      if (ro == 2'd3 && ra == 32'h80000000 && rb == 32'hFFFFFFFF)
        rb = 32'd3;
      @(negedge clk);
      issue(ro, ra, rb, 1, model(ro, ra, rb));
      wait_done(lat);
      check("rand_lat", 64'(lat),
            64'((ro[1] && rb == 0) ? 1 : 34));
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
